// File: rtl/mem_port_arbiter.sv
// Shares one memory read/write channel among C_RPORT read ports and one write port; grant-to-strobe latency 1.
// 4-phase level handshake: requesters hold their level until acked, so requests arriving while busy wait in place.
module mem_port_arbiter #(
  parameter int C_RPORT  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 2,
  parameter int W_STARVE = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [C_RPORT-1:0]         c_re,
  input  logic [C_RPORT*ADDR_W-1:0]  c_raddr,
  input  logic [C_RPORT*LEN_W-1:0]   c_rlen,
  output logic [C_RPORT*DATA_W-1:0]  c_dout,
  output logic [C_RPORT-1:0]         c_rack,
  input  logic                       c_we,
  input  logic [ADDR_W-1:0]          c_waddr,
  input  logic [LEN_W-1:0]           c_wlen,
  input  logic [DATA_W-1:0]          c_din,
  output logic                       c_wack,
  output logic                       c_err,
  output logic                       m_re,
  output logic                       m_we,
  output logic [ADDR_W-1:0]          m_raddr,
  output logic [ADDR_W-1:0]          m_waddr,
  output logic [LEN_W-1:0]           m_rlen,
  output logic [LEN_W-1:0]           m_wlen,
  output logic [DATA_W-1:0]          m_dout,
  input  logic [DATA_W-1:0]          m_din,
  input  logic                       m_rack,
  input  logic                       m_wack
);

  localparam int RR_W = (C_RPORT > 1) ? $clog2(C_RPORT) : 1;
  localparam int ST_W = $clog2(W_STARVE + 2);

  typedef enum logic [1:0] {IDLE, RD, WR, HOLD} state_t;

  state_t            state, state_nxt;
  logic [RR_W-1:0]   rr_ptr, rr_nxt;
  logic [RR_W-1:0]   win_idx;
  logic              win_wr;
  logic [ST_W-1:0]   starve_cnt;
  logic [7:0]        to_cnt;

  logic              hi_any, lo_any, rd_any;
  logic [RR_W-1:0]   hi_win, lo_win, rd_win;
  logic              grant_rd, grant_wr, xfer_ack, xfer_to, hold_rel;

  // Circular priority from rr_ptr: prefer the lowest requester at/after the
  // pointer, else wrap to the lowest requester below it.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_win = '0;
    lo_win = '0;
    for (int i = C_RPORT - 1; i >= 0; i--) begin
      if (c_re[i]) begin
        if (RR_W'(i) >= rr_ptr) begin
          hi_any = 1'b1;
          hi_win = RR_W'(i);
        end else begin
          lo_any = 1'b1;
          lo_win = RR_W'(i);
        end
      end
    end
    rd_any = hi_any | lo_any;
    rd_win = hi_any ? hi_win : lo_win;
    rr_nxt = (rd_win == RR_W'(C_RPORT - 1)) ? '0 : rd_win + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    xfer_ack  = 1'b0;
    xfer_to   = 1'b0;
    hold_rel  = 1'b0;
    case (state)
      IDLE: begin
        if (c_we && (!rd_any || starve_cnt == ST_W'(W_STARVE))) begin
          grant_wr  = 1'b1;
          state_nxt = WR;
        end else if (rd_any) begin
          grant_rd  = 1'b1;
          state_nxt = RD;
        end
      end
      RD: begin
        if (m_rack) begin
          xfer_ack  = 1'b1;
          state_nxt = HOLD;
        end else if (to_cnt == 8'(TIMEOUT - 1)) begin
          xfer_to   = 1'b1;
          state_nxt = HOLD;
        end
      end
      WR: begin
        if (m_wack) begin
          xfer_ack  = 1'b1;
          state_nxt = HOLD;
        end else if (to_cnt == 8'(TIMEOUT - 1)) begin
          xfer_to   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (win_wr ? !c_we : !c_re[win_idx]) begin
          hold_rel  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      win_idx    <= '0;
      win_wr     <= 1'b0;
      starve_cnt <= '0;
      to_cnt     <= '0;
      m_re       <= 1'b0;
      m_we       <= 1'b0;
      m_raddr    <= '0;
      m_waddr    <= '0;
      m_rlen     <= '0;
      m_wlen     <= '0;
      m_dout     <= '0;
      c_dout     <= '0;
      c_rack     <= '0;
      c_wack     <= 1'b0;
      c_err      <= 1'b0;
    end else begin
      // Starvation credit only accrues while a write is actually waiting.
      if (!c_we || grant_wr)
        starve_cnt <= '0;
      else if (grant_rd && starve_cnt != ST_W'(W_STARVE))
        starve_cnt <= starve_cnt + 1'b1;

      if (grant_rd || grant_wr)
        to_cnt <= '0;
      else if (state == RD || state == WR)
        to_cnt <= to_cnt + 1'b1;

      if (grant_rd) begin
        win_idx <= rd_win;
        win_wr  <= 1'b0;
        rr_ptr  <= rr_nxt;
        m_re    <= 1'b1;
        m_raddr <= c_raddr[int'(rd_win)*ADDR_W +: ADDR_W];
        m_rlen  <= c_rlen[int'(rd_win)*LEN_W +: LEN_W];
      end

      if (grant_wr) begin
        win_wr  <= 1'b1;
        m_we    <= 1'b1;
        m_waddr <= c_waddr;
        m_wlen  <= c_wlen;
        m_dout  <= c_din;
      end

      // A timed-out transfer is still acked (with zero data) so the requester
      // can complete its handshake; c_err records the failure.
      if (xfer_ack || xfer_to) begin
        if (win_wr) begin
          m_we   <= 1'b0;
          c_wack <= 1'b1;
        end else begin
          m_re            <= 1'b0;
          c_rack[win_idx] <= 1'b1;
          c_dout[int'(win_idx)*DATA_W +: DATA_W] <= xfer_ack ? m_din : '0;
        end
      end

      if (xfer_to)
        c_err <= 1'b1;

      if (hold_rel) begin
        c_rack <= '0;
        c_wack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single read, round-robin, write starvation, timeout, withdrawal, mid-read reset.
module tb_mem_port_arbiter;

  localparam int C_RPORT = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int LEN_W   = 2;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [C_RPORT-1:0]         c_re;
  logic [C_RPORT*ADDR_W-1:0]  c_raddr;
  logic [C_RPORT*LEN_W-1:0]   c_rlen;
  logic [C_RPORT*DATA_W-1:0]  c_dout;
  logic [C_RPORT-1:0]         c_rack;
  logic                       c_we;
  logic [ADDR_W-1:0]          c_waddr;
  logic [LEN_W-1:0]           c_wlen;
  logic [DATA_W-1:0]          c_din;
  logic                       c_wack;
  logic                       c_err;
  logic                       m_re, m_we;
  logic [ADDR_W-1:0]          m_raddr, m_waddr;
  logic [LEN_W-1:0]           m_rlen, m_wlen;
  logic [DATA_W-1:0]          m_dout;
  logic [DATA_W-1:0]          m_din;
  logic                       m_rack, m_wack;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .C_RPORT(C_RPORT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .W_STARVE(4), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .c_re(c_re), .c_raddr(c_raddr), .c_rlen(c_rlen), .c_dout(c_dout), .c_rack(c_rack),
    .c_we(c_we), .c_waddr(c_waddr), .c_wlen(c_wlen), .c_din(c_din), .c_wack(c_wack),
    .c_err(c_err),
    .m_re(m_re), .m_we(m_we), .m_raddr(m_raddr), .m_waddr(m_waddr),
    .m_rlen(m_rlen), .m_wlen(m_wlen), .m_dout(m_dout), .m_din(m_din),
    .m_rack(m_rack), .m_wack(m_wack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    c_re = '0; c_raddr = '0; c_rlen = '0;
    c_we = 1'b0; c_waddr = '0; c_wlen = '0; c_din = '0;
    m_din = '0; m_rack = 1'b0; m_wack = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({m_re, m_we, c_rack, c_wack, c_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {m_re, m_we, c_rack, c_wack, c_err});
    end
    checks++;
    if (c_dout !== '0 || m_raddr !== '0 || m_waddr !== '0 || m_dout !== '0) begin
      errors++;
      $display("FAIL reset_data: c_dout=%h m_raddr=%h m_waddr=%h m_dout=%h expected all 0",
               c_dout, m_raddr, m_waddr, m_dout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read;
    c_raddr[0 +: ADDR_W] = 32'h1000;
    c_rlen[0 +: LEN_W]   = 2'd2;
    c_re = 2'b01;
    tick();
    checks++;
    if (m_re !== 1'b1 || m_raddr !== 32'h1000 || m_rlen !== 2'd2) begin
      errors++;
      $display("FAIL single_grant: m_re=%b m_raddr=%h m_rlen=%0d expected 1 1000 2", m_re, m_raddr, m_rlen);
    end
    c_raddr[0 +: ADDR_W] = 32'h9999;
    tick();
    tick();
    checks++;
    if (m_re !== 1'b1 || c_rack !== 2'b00 || m_raddr !== 32'h1000) begin
      errors++;
      $display("FAIL single_wait: m_re=%b c_rack=%b m_raddr=%h expected 1 00 1000", m_re, c_rack, m_raddr);
    end
    m_rack = 1'b1;
    m_din  = 64'hDEADBEEF;
    tick();
    m_rack = 1'b0;
    checks++;
    if (m_re !== 1'b0 || c_rack !== 2'b01 || c_dout[0 +: DATA_W] !== 64'hDEADBEEF) begin
      errors++;
      $display("FAIL single_ack: m_re=%b c_rack=%b c_dout0=%h expected 0 01 deadbeef", m_re, c_rack, c_dout[0 +: DATA_W]);
    end
    tick();
    checks++;
    if (c_rack !== 2'b01) begin
      errors++;
      $display("FAIL single_hold: c_rack=%b expected 01", c_rack);
    end
    c_re = 2'b00;
    tick();
    checks++;
    if (c_rack !== 2'b00) begin
      errors++;
      $display("FAIL single_release: c_rack=%b expected 00", c_rack);
    end
    tick();
  endtask

  task automatic test_round_robin;
    do_reset();
    c_raddr = {32'h200, 32'h100};
    m_rack  = 1'b1;
    c_re    = 2'b11;
    for (int g = 0; g < 4; g++) begin
      int p;
      logic [31:0] ea;
      logic [1:0]  eack;
      p    = g % 2;
      ea   = (p == 1) ? 32'h200 : 32'h100;
      eack = (p == 1) ? 2'b10 : 2'b01;
      tick();
      checks++;
      if (m_re !== 1'b1 || m_raddr !== ea) begin
        errors++;
        $display("FAIL rr_grant%0d: m_re=%b m_raddr=%h expected 1 %h", g, m_re, m_raddr, ea);
      end
      m_din = 64'hA000 + 64'(g);
      tick();
      checks++;
      if (c_rack !== eack || c_dout[p*DATA_W +: DATA_W] !== 64'hA000 + 64'(g)) begin
        errors++;
        $display("FAIL rr_ack%0d: c_rack=%b data=%h expected %b %h", g, c_rack,
                 c_dout[p*DATA_W +: DATA_W], eack, 64'hA000 + 64'(g));
      end
      c_re[p] = 1'b0;
      tick();
      checks++;
      if (c_rack !== 2'b00) begin
        errors++;
        $display("FAIL rr_release%0d: c_rack=%b expected 00", g, c_rack);
      end
      c_re[p] = 1'b1;
    end
    c_re = 2'b00;
    m_rack = 1'b0;
    tick();
  endtask

  task automatic test_write_starve;
    do_reset();
    c_raddr = {32'h200, 32'h100};
    c_waddr = 32'h2000;
    c_wlen  = 2'd3;
    c_din   = 64'h55;
    c_we    = 1'b1;
    m_rack  = 1'b1;
    c_re    = 2'b11;
    for (int g = 0; g < 4; g++) begin
      int p;
      logic [31:0] ea;
      p  = g % 2;
      ea = (p == 1) ? 32'h200 : 32'h100;
      tick();
      checks++;
      if (m_re !== 1'b1 || m_we !== 1'b0 || m_raddr !== ea) begin
        errors++;
        $display("FAIL starve_read%0d: m_re=%b m_we=%b m_raddr=%h expected 1 0 %h", g, m_re, m_we, m_raddr, ea);
      end
      m_din = 64'h77 + 64'(g);
      tick();
      c_re[p] = 1'b0;
      tick();
      c_re[p] = 1'b1;
    end
    tick();
    checks++;
    if (m_we !== 1'b1 || m_re !== 1'b0 || m_waddr !== 32'h2000 || m_dout !== 64'h55 || m_wlen !== 2'd3) begin
      errors++;
      $display("FAIL starve_write_grant: m_we=%b m_re=%b m_waddr=%h m_dout=%h m_wlen=%0d expected 1 0 2000 55 3",
               m_we, m_re, m_waddr, m_dout, m_wlen);
    end
    tick();
    checks++;
    if (m_we !== 1'b1 || c_wack !== 1'b0) begin
      errors++;
      $display("FAIL write_wait: m_we=%b c_wack=%b expected 1 0", m_we, c_wack);
    end
    m_wack = 1'b1;
    tick();
    m_wack = 1'b0;
    checks++;
    if (m_we !== 1'b0 || c_wack !== 1'b1) begin
      errors++;
      $display("FAIL write_ack: m_we=%b c_wack=%b expected 0 1", m_we, c_wack);
    end
    c_we   = 1'b0;
    c_re   = 2'b00;
    m_rack = 1'b0;
    tick();
    checks++;
    if (c_wack !== 1'b0) begin
      errors++;
      $display("FAIL write_release: c_wack=%b expected 0", c_wack);
    end
    tick();
  endtask

  task automatic test_timeout;
    c_raddr[0 +: ADDR_W] = 32'h3000;
    m_din  = 64'hFFFF_FFFF;
    m_rack = 1'b0;
    c_re   = 2'b01;
    tick();
    for (int k = 0; k < 254; k++) tick();
    checks++;
    if (m_re !== 1'b1 || c_err !== 1'b0 || c_rack !== 2'b00) begin
      errors++;
      $display("FAIL timeout_before: m_re=%b c_err=%b c_rack=%b expected 1 0 00", m_re, c_err, c_rack);
    end
    tick();
    checks++;
    if (m_re !== 1'b0 || c_err !== 1'b1 || c_rack !== 2'b01 || c_dout[0 +: DATA_W] !== 64'h0) begin
      errors++;
      $display("FAIL timeout_expire: m_re=%b c_err=%b c_rack=%b c_dout0=%h expected 0 1 01 0",
               m_re, c_err, c_rack, c_dout[0 +: DATA_W]);
    end
    c_re = 2'b00;
    tick();
    tick();
    checks++;
    if (c_rack !== 2'b00 || c_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: c_rack=%b c_err=%b expected 00 1", c_rack, c_err);
    end
  endtask

  task automatic test_withdrawal;
    c_raddr = {32'h6000, 32'h5000};
    c_re = 2'b01;
    tick();
    checks++;
    if (m_re !== 1'b1 || m_raddr !== 32'h5000) begin
      errors++;
      $display("FAIL withdraw_grant0: m_re=%b m_raddr=%h expected 1 5000", m_re, m_raddr);
    end
    c_re = 2'b11;
    tick();
    c_re = 2'b01;
    m_rack = 1'b1;
    m_din  = 64'h1234;
    tick();
    m_rack = 1'b0;
    checks++;
    if (c_rack !== 2'b01 || c_dout[0 +: DATA_W] !== 64'h1234) begin
      errors++;
      $display("FAIL withdraw_ack0: c_rack=%b c_dout0=%h expected 01 1234", c_rack, c_dout[0 +: DATA_W]);
    end
    c_re = 2'b00;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (m_re !== 1'b0 || c_rack !== 2'b00 || m_raddr !== 32'h5000) begin
        errors++;
        $display("FAIL withdraw_idle%0d: m_re=%b c_rack=%b m_raddr=%h expected 0 00 5000", k, m_re, c_rack, m_raddr);
      end
    end
    checks++;
    if (c_err !== 1'b1) begin
      errors++;
      $display("FAIL err_persist: c_err=%b expected 1", c_err);
    end
  endtask

  task automatic test_reset_mid_read;
    c_raddr[0 +: ADDR_W] = 32'h4000;
    c_re = 2'b01;
    tick();
    tick();
    checks++;
    if (m_re !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy: m_re=%b expected 1", m_re);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_re !== 1'b0 || c_rack !== 2'b00 || c_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: m_re=%b c_rack=%b c_err=%b expected 0 00 0", m_re, c_rack, c_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (m_re !== 1'b1 || m_raddr !== 32'h4000) begin
      errors++;
      $display("FAIL midreset_regrant: m_re=%b m_raddr=%h expected 1 4000", m_re, m_raddr);
    end
    m_rack = 1'b1;
    m_din  = 64'hCAFE;
    tick();
    m_rack = 1'b0;
    checks++;
    if (c_rack !== 2'b01 || c_dout[0 +: DATA_W] !== 64'hCAFE || c_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ack: c_rack=%b c_dout0=%h c_err=%b expected 01 cafe 0",
               c_rack, c_dout[0 +: DATA_W], c_err);
    end
    c_re = 2'b00;
    tick();
    checks++;
    if (c_rack !== 2'b00) begin
      errors++;
      $display("FAIL midreset_release: c_rack=%b expected 00", c_rack);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_starve();
    test_timeout();
    test_withdrawal();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
